// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter and sequencer sharing one spi_drv master
// between N_REQ requesters. Latches the winner's command, hands it to spi_drv
// through the start_cmd / spi_drv_rdy handshake, and returns the captured
// MISO word with a one-cycle done pulse to the winner.
module spi_arb #(
  parameter int N_REQ       = 4,
  parameter int SPI_MAXLEN  = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic [N_REQ-1:0]                            req,
  input  logic [N_REQ*($clog2(SPI_MAXLEN)+1)-1:0]     req_n_clks,
  input  logic [N_REQ*SPI_MAXLEN-1:0]                 req_tx_data,
  output logic [N_REQ-1:0]                            gnt,
  output logic [N_REQ-1:0]                            done,
  output logic                                        err,
  output logic [SPI_MAXLEN-1:0]                       rx_data,
  output logic [N_REQ-1:0]                            ss_sel,
  output logic                                        start_cmd,
  output logic [$clog2(SPI_MAXLEN):0]                 drv_n_clks,
  output logic [SPI_MAXLEN-1:0]                       drv_tx_data,
  input  logic                                        spi_drv_rdy,
  input  logic [SPI_MAXLEN-1:0]                       rx_miso
);

  localparam int NCW = $clog2(SPI_MAXLEN) + 1;
  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(ACK_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           win_idx;
  logic [IW-1:0]           rr_nx;
  logic                    win_found;
  logic [NCW-1:0]          win_n_clks;
  logic [SPI_MAXLEN-1:0]   win_tx;
  logic                    cmd_bad;
  logic                    err_flag;
  logic [TW-1:0]           tmo_cnt;
  logic                    tmo_hit;
  logic                    take;

  // Round-robin pick: first set req bit at or after rr_ptr, wrapping.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % N_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Winner's command slice, validity check and the following rr pointer.
  always_comb begin
    win_n_clks = req_n_clks[win_idx*NCW +: NCW];
    win_tx     = req_tx_data[win_idx*SPI_MAXLEN +: SPI_MAXLEN];
    cmd_bad    = (win_n_clks == '0) || (win_n_clks > NCW'(SPI_MAXLEN));
    rr_nx      = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + IW'(1);
    take       = win_found && spi_drv_rdy;
    tmo_hit    = (tmo_cnt == TW'(ACK_TIMEOUT));
  end

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (take) state_nx = cmd_bad ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (!spi_drv_rdy)  state_nx = S_BUSY;
        else if (tmo_hit)  state_nx = S_DONE;
      end
      S_BUSY:  if (spi_drv_rdy) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; all are zero while in reset (state IDLE, gnt 0).
  always_comb begin
    start_cmd = (state == S_ISSUE);
    ss_sel    = (state == S_ISSUE || state == S_BUSY) ? gnt : '0;
    done      = (state == S_DONE) ? gnt : '0;
    err       = (state == S_DONE) && err_flag;
  end

  // Grant, latched command, timeout counter and captured MISO word.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      gnt         <= '0;
      rr_ptr      <= '0;
      drv_n_clks  <= '0;
      drv_tx_data <= '0;
      rx_data     <= '0;
      err_flag    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take) begin
            gnt         <= N_REQ'(1) << win_idx;
            drv_n_clks  <= win_n_clks;
            drv_tx_data <= win_tx;
            rr_ptr      <= rr_nx;
            err_flag    <= cmd_bad;
            tmo_cnt     <= '0;
          end
        end
        S_ISSUE: begin
          if (spi_drv_rdy) begin
            if (tmo_hit) err_flag <= 1'b1;
            else         tmo_cnt  <= tmo_cnt + TW'(1);
          end
        end
        S_BUSY: begin
          if (spi_drv_rdy) rx_data <= rx_miso;
        end
        S_DONE: begin
          gnt      <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: a behavioural spi_drv stub that echoes MOSI back as
// MISO, directed requester stimulus, and a scoreboard monitor.
module tb_spi_arb;

  localparam int N   = 4;
  localparam int ML  = 32;
  localparam int TO  = 15;
  localparam int NCW = $clog2(ML) + 1;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N*NCW-1:0]     req_n_clks = '0;
  logic [N*ML-1:0]      req_tx_data = '0;
  logic [N-1:0]         gnt, done, ss_sel;
  logic                 err, start_cmd;
  logic [ML-1:0]        rx_data, drv_tx_data, rx_miso;
  logic [NCW-1:0]       drv_n_clks;
  logic                 spi_drv_rdy;

  logic                 stuck = 1'b0;
  logic                 tb_end = 1'b0;
  logic [NCW-1:0]       stub_cnt;
  logic [ML-1:0]        stub_tx;
  logic [ML-1:0]        last_rx = '0;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          err;
    logic [ML-1:0] rx;
    int            starts;
    int            gcyc;
    int            sscyc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  spi_arb #(.N_REQ(N), .SPI_MAXLEN(ML), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .aresetn(aresetn), .req(req), .req_n_clks(req_n_clks),
    .req_tx_data(req_tx_data), .gnt(gnt), .done(done), .err(err),
    .rx_data(rx_data), .ss_sel(ss_sel), .start_cmd(start_cmd),
    .drv_n_clks(drv_n_clks), .drv_tx_data(drv_tx_data),
    .spi_drv_rdy(spi_drv_rdy), .rx_miso(rx_miso)
  );

  // spi_drv stub: drops rdy one edge after start_cmd, stays busy n_clks
  // edges, then raises rdy with MISO = latched MOSI. 'stuck' ignores start.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      spi_drv_rdy <= 1'b1;
      stub_cnt    <= '0;
      stub_tx     <= '0;
      rx_miso     <= '0;
    end else if (spi_drv_rdy) begin
      if (start_cmd && !stuck) begin
        spi_drv_rdy <= 1'b0;
        stub_cnt    <= drv_n_clks;
        stub_tx     <= drv_tx_data;
      end
    end else if (stub_cnt <= 1) begin
      spi_drv_rdy <= 1'b1;
      rx_miso     <= stub_tx;
    end else begin
      stub_cnt <= stub_cnt - 1'b1;
    end
  end

  task automatic load(input int i, input int n, input logic [ML-1:0] tx);
    req_n_clks[i*NCW +: NCW] = NCW'(n);
    req_tx_data[i*ML +: ML]  = tx;
  endtask

  // kind 0: normal transfer, 1: rejected command, 2: ack timeout.
  task automatic expect_xfer(input int i, input int kind, input int n,
                             input logic [ML-1:0] rx);
    exp_t e;
    e.gnt = N'(1) << i;
    e.err = (kind != 0);
    e.rx  = rx;
    case (kind)
      0: begin e.starts = 2;      e.gcyc = n + 3;  e.sscyc = n + 2;  end
      1: begin e.starts = 0;      e.gcyc = 1;      e.sscyc = 0;      end
      default: begin e.starts = TO + 1; e.gcyc = TO + 2; e.sscyc = TO + 1; end
    endcase
    sbq.push_back(e);
  endtask

  task automatic wait_done(input int n, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (done != '0) begin
        req = req & ~done;
        got++;
      end
    end
  endtask

  // Stimulus.
  initial begin
    repeat (2) @(negedge clk);
    #2 aresetn = 1'b1;
    @(negedge clk);

    // All four request together: served 0,1,2,3 from rr pointer 0.
    load(0, 4, 32'h11); load(1, 4, 32'h22); load(2, 4, 32'h33); load(3, 4, 32'h44);
    expect_xfer(0, 0, 4, 32'h11); expect_xfer(1, 0, 4, 32'h22);
    expect_xfer(2, 0, 4, 32'h33); expect_xfer(3, 0, 4, 32'h44);
    req = 4'b1111;
    wait_done(4, 200);

    // Pointer wrapped after 3: req 1001 serves 0 then 3.
    load(0, 6, 32'h3C); load(3, 16, 32'hBEEF);
    expect_xfer(0, 0, 6, 32'h3C); expect_xfer(3, 0, 16, 32'hBEEF);
    req = 4'b1001;
    wait_done(2, 200);

    // Same requester granted back-to-back.
    load(3, 1, 32'h1);
    expect_xfer(3, 0, 1, 32'h1);
    req = 4'b1000;
    wait_done(1, 50);

    // Single req[1], 8 bits, 0xA5; slice changed after grant must be ignored.
    load(1, 8, 32'hA5);
    expect_xfer(1, 0, 8, 32'hA5);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    load(1, 3, 32'hFFFF_FFFF);
    wait_done(1, 50);
    last_rx = 32'hA5;

    // Rejected commands: n_clks 0 and SPI_MAXLEN+1.
    load(2, 0, 32'hDEAD_BEEF);
    expect_xfer(2, 1, 0, last_rx);
    req = 4'b0100;
    wait_done(1, 3);
    load(2, ML + 1, 32'hCAFE_F00D);
    expect_xfer(2, 1, 0, last_rx);
    req = 4'b0100;
    wait_done(1, 3);

    // spi_drv never acknowledges: timeout, then a normal transfer.
    stuck = 1'b1;
    load(0, 8, 32'h77);
    expect_xfer(0, 2, 8, last_rx);
    req = 4'b0001;
    wait_done(1, 60);
    stuck = 1'b0;
    load(1, 12, 32'hABC);
    expect_xfer(1, 0, 12, 32'hABC);
    req = 4'b0010;
    wait_done(1, 50);

    // Reset mid-BUSY, then a fresh full-length transfer.
    load(2, 32, 32'hFFFF_0000);
    expect_xfer(2, 0, 32, 32'hFFFF_0000);
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ss_sel != '0 && !start_cmd) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 aresetn = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    load(2, 32, 32'h1357_9BDF);
    expect_xfer(2, 0, 32, 32'h1357_9BDF);
    req = 4'b0100;
    wait_done(1, 80);

    repeat (2) @(negedge clk);
    tb_end = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   start_cyc, gnt_cyc, ss_cyc;
    start_cyc = 0; gnt_cyc = 0; ss_cyc = 0;
    forever begin
      @(negedge clk or negedge aresetn);
      #1;
      if (tb_end) begin
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      if (!aresetn) begin
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ss_sel", 64'(ss_sel), 64'd0);
        chk("rst_start_cmd", 64'(start_cmd), 64'd0);
        chk("rst_drv_n_clks", 64'(drv_n_clks), 64'd0);
        chk("rst_drv_tx_data", 64'(drv_tx_data), 64'd0);
        chk("rst_rx_data", 64'(rx_data), 64'd0);
        sbq.delete();
        start_cyc = 0; gnt_cyc = 0; ss_cyc = 0;
      end else begin
        if (start_cmd)     start_cyc++;
        if (gnt != '0)     gnt_cyc++;
        if (ss_sel != '0)  ss_cyc++;
        if (done != '0) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=%0h, expected none", done);
          end else begin
            e = sbq.pop_front();
            chk("done", 64'(done), 64'(e.gnt));
            chk("gnt_in_done", 64'(gnt), 64'(e.gnt));
            chk("err", 64'(err), 64'(e.err));
            chk("rx_data", 64'(rx_data), 64'(e.rx));
            chk("start_cycles", 64'(start_cyc), 64'(e.starts));
            chk("gnt_cycles", 64'(gnt_cyc), 64'(e.gcyc));
            chk("ss_cycles", 64'(ss_cyc), 64'(e.sscyc));
          end
          start_cyc = 0; gnt_cyc = 0; ss_cyc = 0;
        end
      end
    end
  end

endmodule
